// File: rtl/pipe_hazard_pkg.sv
// rtl/pipe_hazard_pkg.sv - shared types for the pipeline hazard controller
// Controller states, forwarding select encodings and the hardwired-zero register.
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The youngest producer wins: EX/MEM holds a newer value than MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem);
    if (m_ex)       fwd_sel = FWD_EXMEM;
    else if (m_mem) fwd_sel = FWD_MEMWB;
    else            fwd_sel = FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
// master is the pipeline datapath, slave is the hazard controller.
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       ID_RS1, ID_RS2;
  logic             ID_USE_RS1, ID_USE_RS2;
  logic [4:0]       EX_RD;
  logic             EX_REGWRITE, EX_MEMREAD;
  logic [4:0]       MEM_RD;
  logic             MEM_REGWRITE;
  logic             EX_REDIRECT, MEM_REQ, MEM_ACK;
  logic             PC_WREN, IFID_WREN, IDEX_WREN, EXMEM_WREN, MEMWB_WREN;
  logic             IFID_FLUSHn, IDEX_FLUSHn;
  logic [1:0]       FWD_A, FWD_B;
  logic             TIMEOUT_ERR;
  logic [CNT_W-1:0] STALL_CNT;

  modport master (
    output ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2, EX_RD, EX_REGWRITE, EX_MEMREAD,
           MEM_RD, MEM_REGWRITE, EX_REDIRECT, MEM_REQ, MEM_ACK,
    input  PC_WREN, IFID_WREN, IDEX_WREN, EXMEM_WREN, MEMWB_WREN,
           IFID_FLUSHn, IDEX_FLUSHn, FWD_A, FWD_B, TIMEOUT_ERR, STALL_CNT
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2, EX_RD, EX_REGWRITE, EX_MEMREAD,
           MEM_RD, MEM_REGWRITE, EX_REDIRECT, MEM_REQ, MEM_ACK,
    output PC_WREN, IFID_WREN, IDEX_WREN, EXMEM_WREN, MEMWB_WREN,
           IFID_FLUSHn, IDEX_FLUSHn, FWD_A, FWD_B, TIMEOUT_ERR, STALL_CNT
  );
endinterface

// File: rtl/pipe_hazard_ctrl_haz_match.sv
// rtl/pipe_hazard_ctrl_haz_match.sv - source-register vs EX/MEM destination compare
// One instance per ID source operand; r0 never matches since it is never written.
module haz_match
  import pipe_hazard_pkg::*;
(
  input  logic [4:0] rs_i,
  input  logic       use_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_regwrite_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_regwrite_i,
  output logic       match_ex_o,
  output logic       match_mem_o
);

  assign match_ex_o  = use_i & ex_regwrite_i  & (ex_rd_i  == rs_i) & (ex_rd_i  != REG_ZERO);
  assign match_mem_o = use_i & mem_regwrite_i & (mem_rd_i == rs_i) & (mem_rd_i != REG_ZERO);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush/forward controller
// Define HAZ_FWD_EN for operand forwarding with load-use-only stalls.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic CLK,
  input  logic RSTn,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e            state_q;
  logic              timeout_err_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [WCNT_W-1:0] wait_cnt_q;

  logic m_ex1, m_mem1, m_ex2, m_mem2, hazard;
  logic pc_wren, ifid_wren, idex_wren, exmem_wren, memwb_wren;
  logic ifid_flushn, idex_flushn, run_rules;

  haz_match u_match_rs1 (
    .rs_i(bus.ID_RS1), .use_i(bus.ID_USE_RS1),
    .ex_rd_i(bus.EX_RD), .ex_regwrite_i(bus.EX_REGWRITE),
    .mem_rd_i(bus.MEM_RD), .mem_regwrite_i(bus.MEM_REGWRITE),
    .match_ex_o(m_ex1), .match_mem_o(m_mem1)
  );

  haz_match u_match_rs2 (
    .rs_i(bus.ID_RS2), .use_i(bus.ID_USE_RS2),
    .ex_rd_i(bus.EX_RD), .ex_regwrite_i(bus.EX_REGWRITE),
    .mem_rd_i(bus.MEM_RD), .mem_regwrite_i(bus.MEM_REGWRITE),
    .match_ex_o(m_ex2), .match_mem_o(m_mem2)
  );

`ifdef HAZ_FWD_EN
  assign hazard = bus.EX_MEMREAD & (m_ex1 | m_ex2);
`else
  // Write-through regfile covers WB; only EX and MEM producers must drain.
  assign hazard = m_ex1 | m_mem1 | m_ex2 | m_mem2;
`endif

  always_comb begin
    pc_wren     = 1'b0;
    ifid_wren   = 1'b0;
    idex_wren   = 1'b0;
    exmem_wren  = 1'b0;
    memwb_wren  = 1'b0;
    ifid_flushn = 1'b1;
    idex_flushn = 1'b1;
    run_rules   = 1'b0;
    if (!RSTn) begin
      ifid_flushn = 1'b0;
      idex_flushn = 1'b0;
    end else begin
      case (state_q)
        RUN:     run_rules = ~(bus.MEM_REQ & ~bus.MEM_ACK);
        MWAIT:   run_rules = bus.MEM_ACK;
        default: run_rules = 1'b0;
      endcase
    end
    if (run_rules) begin
      exmem_wren = 1'b1;
      memwb_wren = 1'b1;
      idex_wren  = 1'b1;
      if (bus.EX_REDIRECT) begin
        pc_wren     = 1'b1;
        ifid_wren   = 1'b1;
        ifid_flushn = 1'b0;
        idex_flushn = 1'b0;
      end else if (hazard) begin
        idex_flushn = 1'b0;
      end else begin
        pc_wren   = 1'b1;
        ifid_wren = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q       <= RUN;
      timeout_err_q <= 1'b0;
      stall_cnt_q   <= '0;
      wait_cnt_q    <= '0;
    end else begin
      if (!pc_wren && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      case (state_q)
        RUN: begin
          if (bus.MEM_REQ && !bus.MEM_ACK) state_q <= MWAIT;
        end
        MWAIT: begin
          if (bus.MEM_ACK) begin
            wait_cnt_q <= '0;
            state_q    <= RUN;
          end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WCNT_W'(MEM_TIMEOUT - 1))) begin
            timeout_err_q <= 1'b1;
            state_q       <= ERR;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
          end
        end
        default: state_q <= ERR;
      endcase
    end
  end

`ifdef HAZ_FWD_EN
  logic [1:0] fwd_a_q, fwd_b_q;

  // A bubble (or reset) entering ID/EX carries no operands to forward.
  always_ff @(posedge CLK) begin
    if (!idex_flushn) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (idex_wren) begin
      fwd_a_q <= fwd_sel(m_ex1, m_mem1);
      fwd_b_q <= fwd_sel(m_ex2, m_mem2);
    end
  end

  assign bus.FWD_A = fwd_a_q;
  assign bus.FWD_B = fwd_b_q;
`else
  assign bus.FWD_A = FWD_RF;
  assign bus.FWD_B = FWD_RF;
`endif

  assign bus.PC_WREN     = pc_wren;
  assign bus.IFID_WREN   = ifid_wren;
  assign bus.IDEX_WREN   = idex_wren;
  assign bus.EXMEM_WREN  = exmem_wren;
  assign bus.MEMWB_WREN  = memwb_wren;
  assign bus.IFID_FLUSHn = ifid_flushn;
  assign bus.IDEX_FLUSHn = idex_flushn;
  assign bus.TIMEOUT_ERR = timeout_err_q;
  assign bus.STALL_CNT   = stall_cnt_q;

endmodule
